supervision_bus_arb: RTL and testbench

- Single-bus arbiter/scheduler for the Supervision system bus (WRAM, VRAM, ROM, control registers).
- Shares the address/data/write bus between three requesters: the CPU (default owner), the block DMA engine, and the audio sample DMA fetcher.
- Drives the CPU RDY stall and per-requester grants.
- Bounds DMA bursts so the CPU is never starved.

---
 rtl/supervision_bus_pkg.sv | 27 ++
 rtl/supervision_bus_arb.sv | 120 ++++++++++++
 tb/tb_supervision_bus_arb.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/supervision_bus_pkg.sv
// rtl/supervision_bus_pkg.sv - shared types and constants for the Supervision bus arbiter
package supervision_bus_pkg;

    localparam int AW_DEFAULT = 16;

    localparam logic [1:0] OWN_CPU  = 2'd0;
    localparam logic [1:0] OWN_DMA  = 2'd1;
    localparam logic [1:0] OWN_ADMA = 2'd2;

    typedef enum logic [1:0] {
        ST_CPU       = 2'd0,
        ST_DMA       = 2'd1,
        ST_ADMA_ADDR = 2'd2,
        ST_ADMA_CAP  = 2'd3
    } arb_state_e;

    // Both audio phases report the audio fetcher as owner.
    function automatic logic [1:0] state_owner(input arb_state_e st);
        case (st)
            ST_DMA:       return OWN_DMA;
            ST_ADMA_ADDR: return OWN_ADMA;
            ST_ADMA_CAP:  return OWN_ADMA;
            default:      return OWN_CPU;
        endcase
    endfunction

endpackage

// File: rtl/supervision_bus_arb.sv
// rtl/supervision_bus_arb.sv - CPU / block DMA / audio DMA arbiter for the Supervision system bus
module supervision_bus_arb
    import supervision_bus_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int AW        = AW_DEFAULT
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_we,
    output logic          cpu_rdy,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_dout,
    input  logic          dma_write,
    output logic          dma_gnt,
    input  logic          adma_req,
    input  logic [AW-1:0] adma_addr,
    output logic          adma_ack,
    output logic [7:0]    adma_data,
    input  logic [7:0]    bus_di,
    output logic [AW-1:0] AB,
    output logic [7:0]    DO,
    output logic          bus_we,
    output logic [1:0]    owner
);

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] adma_data_q, adma_data_d;

    // Next-state: audio beats block DMA beats beat CPU; a DMA run is capped at
    // BURST_LIMIT beats and every DMA exit or audio fetch returns via the CPU.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        adma_data_d = adma_data_q;
        case (state_q)
            ST_CPU: begin
                if (adma_req) begin
                    state_d = ST_ADMA_ADDR;
                end else if (dma_req) begin
                    state_d     = ST_DMA;
                    burst_cnt_d = 8'd1;
                end
            end
            ST_DMA: begin
                if (adma_req) begin
                    state_d     = ST_ADMA_ADDR;
                    burst_cnt_d = 8'd0;
                end else if (!dma_req || burst_cnt_q == BURST_LIMIT) begin
                    state_d     = ST_CPU;
                    burst_cnt_d = 8'd0;
                end else if (burst_cnt_q != 8'hFF) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            ST_ADMA_ADDR: begin
                state_d = ST_ADMA_CAP;
            end
            ST_ADMA_CAP: begin
                adma_data_d = bus_di;
                state_d     = ST_CPU;
            end
            default: begin
                state_d     = ST_CPU;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    // State registers; reset drops any transfer in flight without an ack.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CPU;
            burst_cnt_q <= 8'd0;
            adma_data_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            adma_data_q <= adma_data_d;
        end
    end

    // Bus mux and handshakes decode only the registered state, never the requests.
    always_comb begin
        AB     = cpu_addr;
        DO     = cpu_dout;
        bus_we = cpu_we;
        case (state_q)
            ST_DMA: begin
                AB     = dma_addr;
                DO     = dma_dout;
                bus_we = dma_write;
            end
            ST_ADMA_ADDR, ST_ADMA_CAP: begin
                AB     = adma_addr;
                DO     = 8'd0;
                bus_we = 1'b0;
            end
            default: begin
                AB     = cpu_addr;
                DO     = cpu_dout;
                bus_we = cpu_we;
            end
        endcase
    end

    assign cpu_rdy   = (state_q == ST_CPU);
    assign dma_gnt   = (state_q == ST_DMA);
    assign adma_ack  = (state_q == ST_ADMA_CAP);
    // The fetched byte is visible in the ack cycle itself, then held.
    assign adma_data = (state_q == ST_ADMA_CAP) ? bus_di : adma_data_q;
    assign owner     = state_owner(state_q);

endmodule

// File: tb/tb_supervision_bus_arb.sv
// tb/tb_supervision_bus_arb.sv - scoreboard bench for supervision_bus_arb
module tb_supervision_bus_arb;
    import supervision_bus_pkg::*;

    localparam int MB = 16;
    localparam int AW = 16;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic          cpu_we;
    logic          cpu_rdy;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_dout;
    logic          dma_write;
    logic          dma_gnt;
    logic          adma_req;
    logic [AW-1:0] adma_addr;
    logic          adma_ack;
    logic [7:0]    adma_data;
    logic [7:0]    bus_di;
    logic [AW-1:0] AB;
    logic [7:0]    DO;
    logic          bus_we;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;

    supervision_bus_arb #(.MAX_BURST(MB), .AW(AW)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_write(dma_write),
        .dma_gnt(dma_gnt), .adma_req(adma_req), .adma_addr(adma_addr), .adma_ack(adma_ack),
        .adma_data(adma_data), .bus_di(bus_di), .AB(AB), .DO(DO), .bus_we(bus_we), .owner(owner)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        if (a == 16'hC010) return 8'h5A;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // Registered memory: data for an address appears one clock later.
    always @(posedge clk_sys) bus_di <= mem_f(AB);

    typedef struct packed {
        logic [1:0]  own;
        logic [15:0] ab;
        logic [7:0]  dout;
        logic        we;
        logic        rdy;
        logic        gnt;
        logic        ack;
        logic [7:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] dma_q[$];
    logic [7:0]  adma_q[$];

    // Reference model: owner code, second audio phase flag, length of the current DMA run.
    int         m_own = 0;
    bit         m_cap = 0;
    int         m_run = 0;
    logic [7:0] m_fetch = 8'd0;
    logic [7:0] m_data = 8'd0;

    // Requester models.
    int          dma_left = 0;
    int          dma_done = 0;
    logic [15:0] dma_base = 16'd0;
    bit          adma_pend = 0;
    bit          adma_drop = 0;
    bit          rand_cpu = 0;
    int          cyc = 0;
    int          req_cyc = 0;
    int          ack_lat = -1;
    logic [7:0]  ack_data = 8'd0;
    int          gnt_cnt = 0;
    int          req_cnt = 0;
    int          both_cnt = 0;
    logic [1:0]  own_seen;

    task automatic start_dma(input logic [15:0] base, input int n);
        dma_base = base;
        dma_done = 0;
        dma_left = n;
        for (int i = 0; i < n; i++) dma_q.push_back(base + 16'(i));
    endtask

    task automatic start_adma(input logic [15:0] a, input bit drop);
        adma_addr = a;
        adma_pend = 1;
        adma_drop = drop;
        req_cyc   = cyc;
        ack_lat   = -1;
    endtask

    // One bus cycle: drive inputs, push the expected response, advance the model.
    task automatic tick();
        exp_t e;
        if (rand_cpu) begin
            cpu_addr = 16'($urandom);
            cpu_dout = 8'($urandom);
            cpu_we   = 1'($urandom);
        end
        dma_dout  = 8'($urandom);
        dma_write = 1'($urandom);
        if (reset) begin
            dma_left = 0;
            adma_pend = 0;
            dma_q.delete();
            adma_q.delete();
            dma_req  = 1'b0;
            adma_req = 1'b0;
            m_own = 0; m_cap = 0; m_run = 0; m_data = 8'd0;
        end else begin
            dma_addr = dma_base + 16'(dma_done);
            dma_req  = (dma_left > 0) && !(dma_left == 1 && dma_gnt);
            adma_req = adma_pend && !adma_ack && !(adma_drop && owner == OWN_ADMA);
        end
        own_seen = owner;
        e.own = 2'(m_own);
        case (m_own)
            0:       begin e.ab = cpu_addr;  e.dout = cpu_dout; e.we = cpu_we;    end
            1:       begin e.ab = dma_addr;  e.dout = dma_dout; e.we = dma_write; end
            default: begin e.ab = adma_addr; e.dout = 8'd0;     e.we = 1'b0;      end
        endcase
        e.rdy  = (m_own == 0);
        e.gnt  = (m_own == 1);
        e.ack  = (m_own == 2) && m_cap;
        e.data = e.ack ? m_fetch : m_data;
        exp_q.push_back(e);
        if (m_own == 2 && !m_cap) begin
            m_fetch = mem_f(adma_addr);
            adma_q.push_back(m_fetch);
        end
        if (!reset) begin
            if (m_own == 2) begin
                if (m_cap) begin m_data = m_fetch; m_own = 0; m_cap = 0; end
                else m_cap = 1;
            end else if (adma_req) begin
                m_own = 2; m_cap = 0; m_run = 0;
            end else if (m_own == 0) begin
                if (dma_req) begin m_own = 1; m_run = 1; end
            end else if (!dma_req || m_run == MB) begin
                m_own = 0; m_run = 0;
            end else begin
                m_run++;
            end
            if (dma_req) req_cnt++;
            if (dma_gnt) gnt_cnt++;
            if (dma_gnt && cpu_rdy) both_cnt++;
            if (dma_gnt && dma_left > 0) begin dma_left--; dma_done++; end
            if (adma_ack && adma_pend) begin
                ack_lat = cyc - req_cyc;
                ack_data = adma_data;
                adma_pend = 0;
                adma_drop = 0;
            end
        end
        cyc++;
        @(posedge clk_sys); #1;
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: per-cycle output record plus event-driven DMA beat and audio ack scoreboards.
    initial begin
        exp_t e;
        exp_t a;
        logic [15:0] ea;
        logic [7:0] ed;
        forever begin
            @(negedge clk_sys);
            a.own = owner; a.ab = AB; a.dout = DO; a.we = bus_we;
            a.rdy = cpu_rdy; a.gnt = dma_gnt; a.ack = adma_ack; a.data = adma_data;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual own=%0d ab=%h do=%h we=%b rdy=%b gnt=%b ack=%b data=%h required own=%0d ab=%h do=%h we=%b rdy=%b gnt=%b ack=%b data=%h",
                             $time, a.own, a.ab, a.dout, a.we, a.rdy, a.gnt, a.ack, a.data,
                             e.own, e.ab, e.dout, e.we, e.rdy, e.gnt, e.ack, e.data);
                end
            end
            if (dma_gnt === 1'b1) begin
                checks++;
                if (dma_q.size() == 0) begin
                    errors++;
                    $display("FAIL dma_beat t=%0t actual extra beat ab=%h required no beat", $time, AB);
                end else begin
                    ea = dma_q.pop_front();
                    if (AB !== ea) begin
                        errors++;
                        $display("FAIL dma_beat t=%0t actual ab=%h required ab=%h", $time, AB, ea);
                    end
                end
            end
            if (adma_ack === 1'b1) begin
                checks++;
                if (adma_q.size() == 0) begin
                    errors++;
                    $display("FAIL adma_ack t=%0t actual unexpected ack required none", $time);
                end else begin
                    ed = adma_q.pop_front();
                    if (adma_data !== ed) begin
                        errors++;
                        $display("FAIL adma_data t=%0t actual=%h required=%h", $time, adma_data, ed);
                    end
                end
            end
        end
    end

    initial begin
        int seq[8];
        int exp_seq[8];
        bit fired;
        exp_seq = '{0, 2, 2, 0, 1, 1, 1, 0};
        reset = 1'b1;
        cpu_addr = 16'h0; cpu_dout = 8'h0; cpu_we = 1'b0;
        dma_req = 1'b0; dma_addr = 16'h0; dma_dout = 8'h0; dma_write = 1'b0;
        adma_req = 1'b0; adma_addr = 16'h0;
        @(posedge clk_sys); #1;
        tick(); tick();
        reset = 1'b0;

        // Idle CPU ownership with fixed inputs.
        cpu_addr = 16'h1234; cpu_dout = 8'hA5; cpu_we = 1'b1;
        repeat (5) tick();
        check_int("idle_ab", int'(AB), 32'h1234);
        check_int("idle_rdy", int'(cpu_rdy), 1);
        rand_cpu = 1;

        // 38-beat block transfer: two forced CPU slots.
        gnt_cnt = 0; req_cnt = 0; both_cnt = 0;
        start_dma(16'h8000, 38);
        repeat (45) tick();
        check_int("burst_gnt_total", gnt_cnt, 38);
        check_int("burst_req_cycles", req_cnt, 40);
        check_int("burst_no_overlap", both_cnt, 0);
        check_int("burst_drained", dma_q.size(), 0);

        // Reset in the middle of a DMA run.
        start_dma(16'h9000, 20);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_int("rst_mid_dma_rdy", int'(cpu_rdy), 1);
        check_int("rst_mid_dma_gnt", int'(dma_gnt), 0);
        repeat (3) tick();

        // Audio fetch from the CPU state.
        start_adma(16'hC010, 0);
        repeat (5) tick();
        check_int("adma_latency", ack_lat, 2);
        check_int("adma_data_5a", int'(ack_data), 8'h5A);
        check_int("adma_data_held", int'(adma_data), 8'h5A);

        // Audio request arriving during DMA beat 5.
        fired = 0;
        start_dma(16'h4000, 30);
        for (int i = 0; i < 50; i++) begin
            if (!fired && dma_gnt && dma_done == 4) begin
                start_adma(16'h2222, 0);
                fired = 1;
            end
            tick();
        end
        check_int("preempt_fired", int'(fired), 1);
        check_int("preempt_latency", ack_lat, 2);
        check_int("preempt_beats_done", dma_done, 30);

        // Simultaneous requests from the CPU state, CPU trying to write.
        rand_cpu = 0; cpu_we = 1'b1;
        start_dma(16'h6000, 3);
        start_adma(16'h7777, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            seq[i] = int'(own_seen);
        end
        for (int i = 0; i < 8; i++) check_int($sformatf("simul_order_%0d", i), seq[i], exp_seq[i]);
        rand_cpu = 1;

        // Request dropped during the address phase still completes.
        start_adma(16'h3141, 1);
        repeat (5) tick();
        check_int("drop_early_acked", int'(adma_pend), 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (dma_left == 0 && $urandom_range(7) == 0)
                start_dma(16'($urandom), int'($urandom_range(40, 1)));
            if (!adma_pend && $urandom_range(15) == 0)
                start_adma(16'($urandom), $urandom_range(3) == 0);
            reset = ($urandom_range(499) == 0);
            tick();
            reset = 1'b0;
        end
        for (int i = 0; i < 80; i++) tick();
        @(negedge clk_sys);
        check_int("final_dma_q", dma_q.size(), 0);
        check_int("final_adma_q", adma_q.size(), 0);
        check_int("final_exp_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
